// File: rtl/tile_transpose_unit.sv
// Streams N x N element tiles through a single-tile row buffer, emitting them
// either transposed (columns become lines) or in original row order.
module tile_transpose_unit #(
  parameter int LINE_WIDTH = 512,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [31:0]           ctx_length,
  input  logic                  mode,
  input  logic [LINE_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [LINE_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           lines_out
);

  localparam int N  = LINE_WIDTH / DATA_WIDTH;
  localparam int CW = (N >= 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST       = CW'(N - 1);
  localparam logic [31:0]   ALIGN_MASK = ~(32'(N - 1));

  generate
    if ((LINE_WIDTH % DATA_WIDTH) != 0 || N < 2 || (N & (N - 1)) != 0) begin : g_bad_geometry
      $error("tile_transpose_unit: LINE_WIDTH/DATA_WIDTH must be an exact power of two >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

  state_t                state, state_nxt;
  logic [31:0]           total;
  logic [31:0]           lines_out_q;
  logic                  mode_q;
  logic [CW-1:0]         row_cnt;
  logic [CW-1:0]         col_cnt;
  logic [LINE_WIDTH-1:0] row_buf [N];

  logic        in_xfer;
  logic        out_xfer;
  logic [31:0] total_new;

  assign in_xfer   = (state == FILL)  && in_valid;
  assign out_xfer  = (state == DRAIN) && out_ready;
  assign total_new = ctx_length & ALIGN_MASK;

  assign in_ready  = (state == FILL);
  assign out_valid = (state == DRAIN);
  assign busy      = (state == FILL) || (state == DRAIN);
  assign done      = (state == DONE);
  assign lines_out = lines_out_q;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start) state_nxt = (total_new != 32'd0) ? FILL : DONE;
      end
      FILL: begin
        if (in_xfer && row_cnt == LAST) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (out_xfer && col_cnt == LAST)
          state_nxt = (lines_out_q + 32'd1 == total) ? DONE : FILL;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      total       <= '0;
      mode_q      <= 1'b0;
      row_cnt     <= '0;
      col_cnt     <= '0;
      lines_out_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            total       <= total_new;
            mode_q      <= mode;
            row_cnt     <= '0;
            col_cnt     <= '0;
            lines_out_q <= '0;
          end
        end
        FILL: begin
          // N is a power of two, so the increment wraps to 0 after the last row
          if (in_xfer) row_cnt <= row_cnt + CW'(1);
        end
        DRAIN: begin
          if (out_xfer) begin
            col_cnt     <= col_cnt + CW'(1);
            lines_out_q <= lines_out_q + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Tile storage is data only; stale rows are always overwritten before a drain
  always_ff @(posedge clk) begin
    if (in_xfer) row_buf[row_cnt] <= in_data;
  end

  // Output is a pure function of buffer and col_cnt, so it holds through stalls
  always_comb begin
    out_data = '0;
    if (state == DRAIN) begin
      if (mode_q) begin
        out_data = row_buf[col_cnt];
      end else begin
        for (int r = 0; r < N; r++)
          out_data[r*DATA_WIDTH +: DATA_WIDTH] = row_buf[r][col_cnt*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_tile_transpose_unit.sv
// Scoreboard bench for tile_transpose_unit at 64-bit lines, 16-bit elements (4x4 tiles).
module tb_tile_transpose_unit;

  localparam int LW = 64;
  localparam int DW = 16;
  localparam int N  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [31:0]   ctx_length;
  logic          mode;
  logic [LW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [LW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;
  logic [31:0]   lines_out;

  tile_transpose_unit #(.LINE_WIDTH(LW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .ctx_length(ctx_length), .mode(mode),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .lines_out(lines_out)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int rdy_mode = 0;

  logic [LW-1:0] q_exp [$];
  logic [LW-1:0] m_tile [N];
  int            m_cnt = 0;
  logic          m_mode = 1'b0;

  logic          held_valid = 1'b0;
  logic [LW-1:0] held_data = '0;

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_push;
    logic [LW-1:0] line;
    if (m_mode) begin
      for (int r = 0; r < N; r++) q_exp.push_back(m_tile[r]);
    end else begin
      for (int c = 0; c < N; c++) begin
        line = '0;
        for (int r = 0; r < N; r++) line[r*DW +: DW] = m_tile[r][c*DW +: DW];
        q_exp.push_back(line);
      end
    end
  endtask

  task automatic do_reset;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    ctx_length = '0; mode = 1'b0;
    tick; tick;
    reset = 1'b0;
    m_cnt = 0;
    q_exp.delete();
  endtask

  task automatic start_job(input logic [31:0] len, input logic md);
    ctx_length = len; mode = md; start = 1'b1;
    tick;
    start = 1'b0;
    m_mode = md;
    m_cnt = 0;
  endtask

  task automatic send_line(input logic [LW-1:0] d);
    int g;
    in_data = d; in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < 200) begin tick; g++; end
    if (!in_ready) begin
      check("in_ready_wait", {63'd0, in_ready}, 64'd1);
    end else begin
      tick;
      m_tile[m_cnt] = d;
      m_cnt++;
      if (m_cnt == N) begin model_push; m_cnt = 0; end
    end
  endtask

  task automatic wait_done(input string tag, input logic [31:0] exp_lines);
    int g;
    g = 0;
    while (!done && g < 200) begin tick; g++; end
    check({tag, "_done"}, {63'd0, done}, 64'd1);
    check({tag, "_lines_out"}, {32'd0, lines_out}, {32'd0, exp_lines});
    check({tag, "_sb_empty"}, 64'(q_exp.size()), 64'd0);
  endtask

  function automatic logic [LW-1:0] rc_line(input int r);
    logic [LW-1:0] l;
    for (int c = 0; c < N; c++) l[c*DW +: DW] = 16'(r * 16 + c);
    return l;
  endfunction

  // Sink-side scoreboard and stall-stability monitor
  always @(negedge clk) begin
    if (reset) begin
      held_valid = 1'b0;
    end else begin
      if (held_valid && out_valid) check("stall_stable", out_data, held_data);
      if (!out_valid) check("idle_out_data", out_data, '0);
      if (out_valid && out_ready) begin
        if (q_exp.size() == 0) check("unexpected_out", 64'd1, 64'd0);
        else check("out_line", out_data, q_exp.pop_front());
      end
      held_valid = out_valid && !out_ready;
      held_data  = out_data;
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = 1'b0;
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    // Reset state
    do_reset;
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_lines_out", {32'd0, lines_out}, 64'd0);

    // Transpose, exact latency and done timing
    start_job(32'd4, 1'b0);
    check("t1_busy", {63'd0, busy}, 64'd1);
    check("t1_in_ready", {63'd0, in_ready}, 64'd1);
    check("t1_fill_out_valid", {63'd0, out_valid}, 64'd0);
    for (int r = 0; r < N; r++) send_line(rc_line(r));
    in_valid = 1'b0;
    check("t1_latency", {63'd0, out_valid}, 64'd1);
    check("t1_drain_in_ready", {63'd0, in_ready}, 64'd0);
    repeat (N) tick;
    check("t1_done_timing", {63'd0, done}, 64'd1);
    check("t1_busy_off", {63'd0, busy}, 64'd0);
    check("t1_lines_out", {32'd0, lines_out}, 64'd4);
    check("t1_sb_empty", 64'(q_exp.size()), 64'd0);

    // Bypass with a toggling sink, two tiles
    rdy_mode = 1;
    start_job(32'd8, 1'b1);
    check("t2_lines_cleared", {32'd0, lines_out}, 64'd0);
    check("t2_done_cleared", {63'd0, done}, 64'd0);
    for (int i = 0; i < 8; i++) send_line({$urandom, $urandom});
    in_valid = 1'b0;
    wait_done("t2", 32'd8);
    rdy_mode = 0;

    // ctx_length rounded down to a whole tile
    start_job(32'd6, 1'b0);
    for (int i = 0; i < N; i++) send_line({$urandom, $urandom});
    in_valid = 1'b0;
    wait_done("t3a", 32'd4);
    tick; tick;
    check("t3a_no_refill", {63'd0, in_ready}, 64'd0);

    // Sub-tile job completes immediately with no input
    do_reset;
    start_job(32'd3, 1'b0);
    check("t3b_done_next", {63'd0, done}, 64'd1);
    check("t3b_busy", {63'd0, busy}, 64'd0);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("t3b_in_ready", {63'd0, in_ready}, 64'd0);
      tick;
    end
    in_valid = 1'b0;

    // Back-pressure during DRAIN; a start pulsed mid-DRAIN must be ignored
    do_reset;
    rdy_mode = 2;
    start_job(32'd4, 1'b0);
    for (int r = 0; r < N; r++) send_line({$urandom, $urandom});
    in_data = 64'hDEAD_BEEF_CAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      check("t4_drain_in_ready", {63'd0, in_ready}, 64'd0);
      check("t4_drain_valid", {63'd0, out_valid}, 64'd1);
      tick;
    end
    ctx_length = 32'd100; mode = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    check("t4_still_drain", {63'd0, out_valid}, 64'd1);
    rdy_mode = 0;
    wait_done("t4", 32'd4);
    check("t4_done_in_ready", {63'd0, in_ready}, 64'd0);
    in_valid = 1'b0;

    // Reset mid-FILL discards the partial tile
    do_reset;
    start_job(32'd4, 1'b0);
    send_line(64'h1111_1111_1111_1111);
    send_line(64'h2222_2222_2222_2222);
    in_valid = 1'b0;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    m_cnt = 0;
    check("t5_rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("t5_rst_busy", {63'd0, busy}, 64'd0);
    check("t5_rst_done", {63'd0, done}, 64'd0);
    check("t5_rst_lines_out", {32'd0, lines_out}, 64'd0);
    start_job(32'd4, 1'b0);
    for (int r = 0; r < N; r++) send_line(rc_line(r + 4));
    in_valid = 1'b0;
    wait_done("t5", 32'd4);

    tick;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
